// File: rtl/universal_register.sv
// Universal register: hold / parallel load / shift / rotate / up-down count,
// with a serial output bit and a one-cycle wrap pulse on counter roll-over.
module universal_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             wrap
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHR  = 3'b010,
    M_SHL  = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_UP   = 3'b110,
    M_DN   = 3'b111
  } mode_e;

  mode_e op;
  assign op = mode_e'(mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= RST_VALUE;
      ser_out  <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      // wrap is a pulse: cleared every cycle unless a counting op rolls over
      wrap <= 1'b0;
      if (en) begin
        unique case (op)
          M_HOLD: ;
          M_LOAD: data_out <= data_in;
          M_SHR: begin
            data_out <= {ser_in, data_out[WIDTH-1:1]};
            ser_out  <= data_out[0];
          end
          M_SHL: begin
            data_out <= {data_out[WIDTH-2:0], ser_in};
            ser_out  <= data_out[WIDTH-1];
          end
          M_ROR: begin
            data_out <= {data_out[0], data_out[WIDTH-1:1]};
            ser_out  <= data_out[0];
          end
          M_ROL: begin
            data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]};
            ser_out  <= data_out[WIDTH-1];
          end
          M_UP: begin
            data_out <= data_out + 1'b1;
            wrap     <= &data_out;
          end
          M_DN: begin
            data_out <= data_out - 1'b1;
            wrap     <= ~|data_out;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_universal_register.sv
// Scoreboarded random + directed bench for universal_register; two instances
// share stimulus so both the zero and non-zero reset values are covered.
module tb_universal_register;

  logic       clk = 1'b0;
  logic       rst, en, ser_in;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic [7:0] dout_a, dout_b;
  logic       so_a, so_b, wr_a, wr_b;

  universal_register #(.WIDTH(8), .RST_VALUE(8'h00)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .ser_in(ser_in), .data_out(dout_a), .ser_out(so_a), .wrap(wr_a));

  universal_register #(.WIDTH(8), .RST_VALUE(8'h3C)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .ser_in(ser_in), .data_out(dout_b), .ser_out(so_b), .wrap(wr_b));

  always #5 clk = ~clk;

  typedef struct { int d; int so; int w; } mst_t;
  typedef struct { mst_t a; mst_t b; } exp_t;

  exp_t q[$];
  mst_t st_a, st_b;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  // Reference behaviour written as plain integer arithmetic on an 8-bit value.
  function automatic mst_t nxt(mst_t s, bit r, bit e, int md, int di, int si, int rv);
    mst_t n = s;
    int   b;
    n.w = 0;
    if (r) begin
      n.d = rv; n.so = 0;
    end else if (e) begin
      case (md)
        1: n.d = di;
        2: begin n.so = s.d % 2;   n.d = s.d / 2 + si * 128; end
        3: begin n.so = s.d / 128; n.d = (s.d * 2) % 256 + si; end
        4: begin b = s.d % 2;   n.so = b; n.d = s.d / 2 + b * 128; end
        5: begin b = s.d / 128; n.so = b; n.d = (s.d * 2) % 256 + b; end
        6: begin n.w = (s.d == 255); n.d = (s.d + 1) % 256; end
        7: begin n.w = (s.d == 0);   n.d = (s.d + 255) % 256; end
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic step(bit r, bit e, int md, int di, int si);
    exp_t x;
    rst = r; en = e; mode = md[2:0]; data_in = di[7:0]; ser_in = si[0];
    st_a = nxt(st_a, r, e, md, di, si, 8'h00);
    st_b = nxt(st_b, r, e, md, di, si, 8'h3C);
    x.a = st_a; x.b = st_b;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic chk(string name, int act, int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every clock the DUT presents a result; pop and compare.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("data_out_a", int'(dout_a), x.a.d);
        chk("ser_out_a",  int'(so_a),   x.a.so);
        chk("wrap_a",     int'(wr_a),   x.a.w);
        chk("data_out_b", int'(dout_b), x.b.d);
        chk("ser_out_b",  int'(so_b),   x.b.so);
        chk("wrap_b",     int'(wr_b),   x.b.w);
      end
    end
  end

  initial begin
    int vals[5] = '{8'h00, 8'hFF, 8'hFE, 8'h01, 8'h10};
    st_a = '{0, 0, 0}; st_b = '{0, 0, 0};
    // reset with load requested
    step(1, 1, 1, 8'hA5, 0);
    // load, shift right x3 with ser_in=1
    step(0, 1, 1, 8'hA5, 0);
    repeat (3) step(0, 1, 2, 8'h00, 1);
    // rotate left then right
    step(0, 1, 1, 8'h81, 0);
    step(0, 1, 5, 8'h00, 0);
    step(0, 1, 4, 8'h00, 0);
    // count up across the top
    step(0, 1, 1, 8'hFE, 0);
    repeat (3) step(0, 1, 6, 8'h00, 0);
    // count down from zero, then disabled for two cycles
    step(0, 1, 1, 8'h00, 0);
    step(0, 1, 7, 8'h00, 0);
    repeat (2) step(0, 0, 6, 8'h00, 0);
    // reset mid-count and mid-shift
    step(0, 1, 1, 8'h10, 0);
    repeat (2) step(0, 1, 6, 8'h00, 0);
    step(1, 1, 6, 8'h00, 0);
    step(0, 1, 6, 8'h00, 0);
    step(0, 1, 3, 8'h00, 1);
    step(1, 1, 3, 8'h00, 1);
    step(0, 1, 3, 8'h00, 1);
    // alternating up/down at the boundary pulses every time
    step(0, 1, 1, 8'hFF, 0);
    repeat (2) begin step(0, 1, 6, 0, 0); step(0, 1, 7, 0, 0); end
    step(0, 1, 0, 8'h55, 1);
    // shift left / hold with en=1
    step(0, 1, 1, 8'hC3, 0);
    step(0, 1, 3, 8'h00, 0);
    step(0, 1, 0, 8'hAA, 1);
    // randomized mix
    repeat (600) begin
      int di;
      di = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : vals[$urandom_range(0, 4)];
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
           $urandom_range(0, 7), di, $urandom_range(0, 1));
    end
    @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (legal range 2..32).
REQ-002 Parameter RST_VALUE, default 0, value loaded into data_out on reset (WIDTH bits).
REQ-003 clk  input  1  rising-edge clock; all state updates on posedge clk only.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 en  input  1  operation enable; 0 = hold regardless of mode.
REQ-006 mode  input  3  operation select, encoding per REQ-012.
REQ-007 data_in  input  WIDTH  parallel load value.
REQ-008 ser_in  input  1  serial fill bit for shift modes.
REQ-009 data_out  output  WIDTH  register contents (registered, no combinational path from inputs).
REQ-010 ser_out  output  1  bit shifted out on the last shift cycle (registered).
REQ-011 wrap  output  1  one-cycle registered pulse on count wrap-around.

Function
REQ-012 mode encoding: 000 hold; 001 load; 010 shift right; 011 shift left; 100 rotate right; 101 rotate left; 110 count up; 111 count down.
REQ-013 en=0: data_out and ser_out hold; wrap = 0 next cycle.
REQ-014 Load: data_out <= data_in; ser_out holds.
REQ-015 Shift right: data_out <= {ser_in, data_out[WIDTH-1:1]}; ser_out <= data_out[0].
REQ-016 Shift left: data_out <= {data_out[WIDTH-2:0], ser_in}; ser_out <= data_out[WIDTH-1].
REQ-017 Rotate right/left: same as REQ-015/016 with fill bit = bit shifted out; ser_out <= bit shifted out; ser_in ignored.
REQ-018 Count up: data_out <= data_out + 1 modulo 2^WIDTH; wrap <= 1 only when data_out was all-ones.
REQ-019 Count down: data_out <= data_out - 1 modulo 2^WIDTH; wrap <= 1 only when data_out was zero.
REQ-020 wrap is 0 on every cycle not covered by REQ-018/019; never held high two cycles unless two consecutive wraps occur (WIDTH-wide counter cannot, except alternating up/down at boundary, which SHALL pulse each time).
REQ-021 Latency: every operation visible on data_out exactly one clock after the sampling edge.
REQ-022 Mode may change every cycle; no internal state other than data_out, ser_out, wrap.
REQ-023 Hold mode (000) with en=1 behaves identically to en=0.

Reset
REQ-024 rst=1 at posedge: data_out <= RST_VALUE, ser_out <= 0, wrap <= 0.
REQ-025 rst has priority over en and all modes, including mid-count and mid-shift sequences.
REQ-026 First operation after rst deassertion acts on RST_VALUE; no recovery cycles.
REQ-027 Outputs undefined before first reset edge; bench SHALL reset before checking.

Verification (WIDTH=8, RST_VALUE=0 unless noted)
REQ-028 rst=1 one cycle with en=1, mode=001, data_in=8'hA5 -> data_out=8'h00, ser_out=0, wrap=0.
REQ-029 Load 8'hA5, then shift right 3 cycles with ser_in=1 -> data_out 8'hD2, 8'hE9, 8'hF4; ser_out 1,0,1.
REQ-030 Load 8'h81, rotate left 1 cycle -> data_out=8'h03, ser_out=1; rotate right 1 cycle -> 8'h81, ser_out=1.
REQ-031 Load 8'hFE, count up 2 cycles -> data_out 8'hFF (wrap=0), 8'h00 (wrap=1); third count -> 8'h01, wrap=0.
REQ-032 data_out=8'h00, count down 1 cycle -> 8'hFF, wrap=1; then en=0 with mode=110 for 2 cycles -> 8'hFF held, wrap=0.
REQ-033 Counting from 8'h10, assert rst mid-sequence together with en=1 -> data_out=8'h00 next edge; repeat with RST_VALUE=8'h3C -> 8'h3C.
